// File: rtl/ccta_chk_pkg.sv
// Shared definitions for the CCTA response checker: state encoding and default widths.
// Used by ccta_chk_fifo and ccta_resp_checker.
package ccta_chk_pkg;

    localparam int DATA_W_DEF = 5;
    localparam int CNT_W_DEF  = 8;
    localparam int DEPTH_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_HALT = 2'd3
    } chk_state_t;

endpackage

// File: rtl/ccta_chk_fifo.sv
// Synchronous DEPTH x DATA_W FIFO holding expected results; flush empties it in one cycle.
// Pushes while full and pops while empty are ignored.
module ccta_chk_fifo
    import ccta_chk_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ccta_resp_checker.sv
// On-chip scoreboard comparing the CCTA q stream against queued expected results.
// Optional CHK_STOP_ON_FAIL_EN: first mismatch freezes the checker in HALT.
module ccta_resp_checker
    import ccta_chk_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              eot,
    input  logic              exp_valid,
    input  logic [DATA_W-1:0] exp_data,
    output logic              exp_ready,
    input  logic              obs_valid,
    input  logic [DATA_W-1:0] obs_data,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              err,
    output logic              underflow,
    output logic [CNT_W-1:0]  ff_idx,
    output logic [DATA_W-1:0] ff_exp,
    output logic [DATA_W-1:0] ff_obs,
    output logic              done,
    output chk_state_t        dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    chk_state_t        state_q, state_d;
    logic              eot_seen_q, eot_seen_d;
    logic [CNT_W-1:0]  pass_q, pass_d, fail_q, fail_d, idx_q, idx_d, ffi_q, ffi_d;
    logic [DATA_W-1:0] ffe_q, ffe_d, ffo_q, ffo_d;
    logic              err_q, err_d, under_q, under_d;

    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic              obs_run, cmp_en, ufl_ev, mism;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // start outranks any compare in the same cycle; the FIFO is flushed by it.
    assign obs_run   = (state_q == ST_RUN) && obs_valid && !start;
    assign cmp_en    = obs_run && !fifo_empty;
    assign ufl_ev    = obs_run && fifo_empty;
    assign mism      = cmp_en && (fifo_rdata != obs_data);
    assign exp_ready = (state_q == ST_RUN) && !fifo_full;
    assign fifo_push = exp_valid && exp_ready;
    assign fifo_pop  = cmp_en;

    ccta_chk_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start),
        .push  (fifo_push),
        .wdata (exp_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        eot_seen_d = eot_seen_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        idx_d      = idx_q;
        err_d      = err_q;
        under_d    = under_q;
        ffi_d      = ffi_q;
        ffe_d      = ffe_q;
        ffo_d      = ffo_q;
        if (start) begin
            state_d    = ST_RUN;
            eot_seen_d = 1'b0;
            pass_d     = '0;
            fail_d     = '0;
            idx_d      = '0;
            err_d      = 1'b0;
            under_d    = 1'b0;
            ffi_d      = '0;
            ffe_d      = '0;
            ffo_d      = '0;
        end else if (state_q == ST_RUN) begin
            if (eot) eot_seen_d = 1'b1;
            if (ufl_ev) begin
                under_d = 1'b1;
                err_d   = 1'b1;
            end
            if (cmp_en) begin
                idx_d = sat_inc(idx_q);
                if (mism) begin
                    fail_d = sat_inc(fail_q);
                    err_d  = 1'b1;
                    // Saturation keeps fail_q nonzero once set, so this fires only once.
                    if (fail_q == '0) begin
                        ffi_d = idx_q;
                        ffe_d = fifo_rdata;
                        ffo_d = obs_data;
                    end
                end else begin
                    pass_d = sat_inc(pass_q);
                end
            end
`ifdef CHK_STOP_ON_FAIL_EN
            if (mism) state_d = ST_HALT;
            else if ((eot_seen_q || eot) && fifo_empty) state_d = ST_DONE;
`else
            if ((eot_seen_q || eot) && fifo_empty) state_d = ST_DONE;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            eot_seen_q <= 1'b0;
            pass_q     <= '0;
            fail_q     <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            under_q    <= 1'b0;
            ffi_q      <= '0;
            ffe_q      <= '0;
            ffo_q      <= '0;
        end else begin
            state_q    <= state_d;
            eot_seen_q <= eot_seen_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            under_q    <= under_d;
            ffi_q      <= ffi_d;
            ffe_q      <= ffe_d;
            ffo_q      <= ffo_d;
        end
    end

    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;
    assign err       = err_q;
    assign underflow = under_q;
    assign ff_idx    = ffi_q;
    assign ff_exp    = ffe_q;
    assign ff_obs    = ffo_q;
    assign done      = (state_q == ST_DONE) || (state_q == ST_HALT);
    assign dbg_state = state_q;

endmodule
